// File: rtl/mdio_responder.sv
// mdio_responder: MDIO management-frame responder clocked directly by MDC.
//   Parameter PHY_ADDR : PHY address answered when MDIO_PHYAD_CHECK_EN is defined.
//   clk, reset         : bit clock (MDC) and synchronous active-high reset.
//   MDIO_OUT/MDIO_OE   : serial bit and drive enable from the controller.
//   RD_DATA            : register read data, combinational from ADDR.
//   MDIO_IN/MDIO_IN_OE : serial bit and drive enable back to the controller.
//   ADDR, WR_DATA      : register address and write data of the serviced frame.
//   WR_STB, RD_STB     : one-cycle write / read strobes.
// Macro MDIO_PHYAD_CHECK_EN: when defined, frames with PHYAD != PHY_ADDR are
// clocked through silently; when undefined, PHYAD is ignored.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB
);
  localparam logic [3:0] IDLE       = 4'b0001;
  localparam logic [3:0] HEADER     = 4'b0010;
  localparam logic [3:0] WRITE_DATA = 4'b0100;
  localparam logic [3:0] READ_DATA  = 4'b1000;
`ifdef MDIO_PHYAD_CHECK_EN
  localparam logic CHECK = 1'b1;
`else
  localparam logic CHECK = 1'b0;
`endif
  logic [3:0]  state;
  logic [5:0]  cnt;
  logic [5:0]  nxt;
  logic [11:0] hdr;
  logic [12:0] hdr_full;
  logic [15:0] sr;
  logic        skip;
  logic        start;
  logic        bad;
  logic        is_wr;
  logic        hit;
  // cnt holds the number of frame bits already sampled; nxt is the bit sampled now
  assign nxt      = cnt + 6'd1;
  // header bits 2..14: [12] ST low bit, [11:10] OP, [9:5] PHYAD, [4:0] REGAD
  assign hdr_full = {hdr, MDIO_OUT};
  assign start    = MDIO_OE && !MDIO_OUT;
  assign bad      = !hdr_full[12] || (hdr_full[11] == hdr_full[10]);
  assign is_wr    = hdr_full[10];
  assign hit      = !CHECK || (hdr_full[9:5] == PHY_ADDR);
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      hdr        <= 12'd0;
      sr         <= 16'd0;
      skip       <= 1'b0;
      MDIO_IN    <= 1'b0;
      MDIO_IN_OE <= 1'b0;
      ADDR       <= 5'd0;
      WR_DATA    <= 16'd0;
      WR_STB     <= 1'b0;
      RD_STB     <= 1'b0;
    end else begin
      WR_STB <= 1'b0;
      RD_STB <= 1'b0;
      cnt    <= nxt;
      case (state)
        IDLE: begin
          state <= start ? HEADER : IDLE;
          cnt   <= start ? 6'd1 : 6'd0;
        end
        HEADER: begin
          hdr <= {hdr[10:0], MDIO_OUT};
          if (nxt == 6'd14) begin
            state  <= bad ? IDLE : (is_wr ? WRITE_DATA : READ_DATA);
            cnt    <= bad ? 6'd0 : nxt;
            skip   <= !hit;
            RD_STB <= !bad && hit && !is_wr;
            if (!bad && hit) ADDR <= hdr_full[4:0];
          end
        end
        WRITE_DATA: begin
          sr <= {sr[14:0], MDIO_OUT};
          // controller releasing the line mid-write abandons the frame
          if (!MDIO_OE || nxt == 6'd32) begin
            state <= IDLE;
            cnt   <= 6'd0;
          end
          if (MDIO_OE && nxt == 6'd32 && !skip) begin
            WR_DATA <= {sr[14:0], MDIO_OUT};
            WR_STB  <= 1'b1;
          end
        end
        READ_DATA: begin
          if (nxt == 6'd15) begin
            sr         <= RD_DATA;
            MDIO_IN_OE <= !skip;
            MDIO_IN    <= 1'b0;
          end else if (nxt == 6'd32) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            MDIO_IN_OE <= 1'b0;
            MDIO_IN    <= 1'b0;
          end else begin
            MDIO_IN <= !skip && sr[15];
            sr      <= {sr[14:0], 1'b0};
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 6'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: table-driven frame checks for mdio_responder (PHY_ADDR=1),
// plus hand sequences for mid-frame reset and trailing idle; honours MDIO_PHYAD_CHECK_EN.
module tb_mdio_responder;
`ifdef MDIO_PHYAD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [4:0] PA_W = CHK ? 5'd1 : 5'd0;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MDIO_OUT = 1'b1;
  logic        MDIO_OE = 1'b0;
  logic [15:0] RD_DATA;
  logic        MDIO_IN;
  logic        MDIO_IN_OE;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        RD_STB;
  logic [15:0] regs [32];
  assign RD_DATA = regs[ADDR];
  always #5 clk = ~clk;
  mdio_responder #(.PHY_ADDR(5'd1)) dut (
    .clk(clk), .reset(reset), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
    .RD_DATA(RD_DATA), .MDIO_IN(MDIO_IN), .MDIO_IN_OE(MDIO_IN_OE),
    .ADDR(ADDR), .WR_DATA(WR_DATA), .WR_STB(WR_STB), .RD_STB(RD_STB)
  );
  typedef struct {
    int          pre;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] d;
    int          drop;
    bit          rd_oe;
    bit          exp_wr;
    bit          exp_rd;
    logic [4:0]  exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;
  vec_t tbl [12];
  vec_t rd_v;
  vec_t wr_v;
  int n_cmp = 0;
  int n_bad = 0;
  int wr_n, rd_n, oe_err, in_err;
  bit wr_pos_bad, rd_pos_bad;
  logic [15:0] rx;
  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // drives frame bits 1..last (after an optional preamble) and gathers observations
  task automatic run(input vec_t v, input int stop);
    logic [31:0] f;
    bit valid, rd;
    int last, c;
    f = {v.st, v.op, v.pa, v.ra, 2'b10, v.d};
    valid = v.st == 2'b01 && (v.op == 2'b01 || v.op == 2'b10);
    rd = valid && v.op == 2'b10;
    if (rd) regs[v.ra] = v.d;
    last = (stop != 0) ? stop - 1 : 32;
    wr_n = 0; rd_n = 0; oe_err = 0; in_err = 0;
    wr_pos_bad = 0; rd_pos_bad = 0; rx = 16'd0;
    for (int n = 1 - v.pre; n <= last; n++) begin
      if (n < 1) begin
        MDIO_OE = 1'b1; MDIO_OUT = 1'b1;
      end else if (n >= 15 && !valid) begin
        MDIO_OE = 1'b1; MDIO_OUT = 1'b1;
      end else if (n >= 15 && rd) begin
        MDIO_OE = v.rd_oe; MDIO_OUT = v.rd_oe ? 1'($urandom) : 1'b1;
      end else if (v.drop != 0 && n >= v.drop) begin
        MDIO_OE = 1'b0; MDIO_OUT = 1'b1;
      end else begin
        MDIO_OE = 1'b1; MDIO_OUT = f[5'(32 - n)];
      end
      @(posedge clk); #1;
      c = n + 1;
      if (WR_STB) begin wr_n++; if (c != 33) wr_pos_bad = 1; end
      if (RD_STB) begin rd_n++; if (c != 15) rd_pos_bad = 1; end
      if (MDIO_IN_OE !== (v.exp_rd && c >= 16 && c <= 32)) oe_err++;
      if ((!MDIO_IN_OE || c == 16) && MDIO_IN !== 1'b0) in_err++;
      if (c >= 17 && c <= 32) rx = {rx[14:0], MDIO_IN};
    end
  endtask
  task automatic check(input vec_t v, input int i);
    cmp($sformatf("v%0d wr_stb", i), 64'(wr_n + 100 * int'(wr_pos_bad)), 64'(v.exp_wr));
    cmp($sformatf("v%0d rd_stb", i), 64'(rd_n + 100 * int'(rd_pos_bad)), 64'(v.exp_rd));
    cmp($sformatf("v%0d in_oe errors", i), 64'(oe_err), 64'd0);
    cmp($sformatf("v%0d in errors", i), 64'(in_err), 64'd0);
    if (v.exp_rd) cmp($sformatf("v%0d rx data", i), 64'(rx), 64'(v.d));
    cmp($sformatf("v%0d addr", i), 64'(ADDR), 64'(v.exp_addr));
    cmp($sformatf("v%0d wr_data", i), 64'(WR_DATA), 64'(v.exp_wdata));
  endtask
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 16'hD000 | 16'(i);
    tbl[0]  = '{0,  2'b01, 2'b01, PA_W,  5'h03, 16'hA5A5, 0,  1'b0, 1'b1, 1'b0, 5'h03, 16'hA5A5};
    tbl[1]  = '{0,  2'b01, 2'b10, 5'd1,  5'h1F, 16'h1234, 0,  1'b0, 1'b0, 1'b1, 5'h1F, 16'hA5A5};
    tbl[2]  = '{0,  2'b00, 2'b01, 5'd1,  5'h07, 16'h0000, 0,  1'b0, 1'b0, 1'b0, 5'h1F, 16'hA5A5};
    tbl[3]  = '{32, 2'b01, 2'b11, 5'd1,  5'h08, 16'hFFFF, 0,  1'b0, 1'b0, 1'b0, 5'h1F, 16'hA5A5};
    tbl[4]  = '{0,  2'b01, 2'b00, 5'd1,  5'h09, 16'h0F0F, 0,  1'b0, 1'b0, 1'b0, 5'h1F, 16'hA5A5};
    tbl[5]  = '{0,  2'b01, 2'b01, 5'd1,  5'h12, 16'hFFFF, 0,  1'b0, 1'b1, 1'b0, 5'h12, 16'hFFFF};
    tbl[6]  = '{0,  2'b01, 2'b01, 5'd1,  5'h00, 16'h0001, 0,  1'b0, 1'b1, 1'b0, 5'h00, 16'h0001};
    tbl[7]  = '{0,  2'b01, 2'b10, 5'd1,  5'h00, 16'h8001, 0,  1'b1, 1'b0, 1'b1, 5'h00, 16'h0001};
    tbl[8]  = '{0,  2'b01, 2'b01, 5'd1,  5'h04, 16'h1111, 25, 1'b0, 1'b0, 1'b0, 5'h04, 16'h0001};
    tbl[9]  = '{0,  2'b01, 2'b01, 5'd2,  5'h0A, 16'h5A5A, 0,  1'b0, !CHK, 1'b0,
                CHK ? 5'h04 : 5'h0A, CHK ? 16'h0001 : 16'h5A5A};
    tbl[10] = '{0,  2'b01, 2'b01, 5'd1,  5'h0A, 16'h5A5A, 0,  1'b0, 1'b1, 1'b0, 5'h0A, 16'h5A5A};
    tbl[11] = '{0,  2'b01, 2'b10, 5'd1,  5'h15, 16'hFFFF, 0,  1'b0, 1'b0, 1'b1, 5'h15, 16'h5A5A};
    rd_v    = '{0,  2'b01, 2'b10, 5'd1,  5'h1F, 16'hBEEF, 0,  1'b0, 1'b0, 1'b1, 5'h1F, 16'h5A5A};
    wr_v    = '{0,  2'b01, 2'b01, 5'd1,  5'h06, 16'hC3C3, 0,  1'b0, 1'b1, 1'b0, 5'h06, 16'hC3C3};
    repeat (3) @(posedge clk);
    #1;
    cmp("reset outputs", 64'({MDIO_IN, MDIO_IN_OE, ADDR, WR_DATA, WR_STB, RD_STB}), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run(tbl[i], 0);
      check(tbl[i], i);
    end
    run(rd_v, 20);
    cmp("read active before reset", 64'(MDIO_IN_OE), 64'd1);
    reset = 1'b1; MDIO_OE = 1'b1; MDIO_OUT = 1'b0;
    @(posedge clk); #1;
    cmp("mid-frame reset outputs", 64'({MDIO_IN, MDIO_IN_OE, ADDR, WR_DATA, WR_STB, RD_STB}), 64'd0);
    reset = 1'b0;
    run(wr_v, 0);
    check(wr_v, 12);
    MDIO_OE = 1'b1; MDIO_OUT = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("trailing idle", 64'({WR_STB, RD_STB, MDIO_IN_OE, MDIO_IN}), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
